fht_control_param: RTL

- Parametrised FHT address/control sequencer, next generation of the fixed-size FHT controller.
- Sits between the 4-bank data RAMs, coefficient ROM and butterfly pipeline.
- Per cycle it issues four read addresses, one coefficient address, and delayed write addresses with bank write enables, stage by stage.
- Adds over the previous generation: generic transform size, configurable butterfly latency, runtime stage count, stall input, abort, and a done pulse.

---
 rtl/fht_control_param_pkg.sv | 30 +++
 rtl/fht_control_param_if.sv | 33 +++
 rtl/fht_control_param_addr_delay.sv | 24 ++
 rtl/fht_control_param.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fht_control_param_pkg.sv
// Shared types and helpers for the parametrised FHT address/control sequencer.
package fht_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_FIN
  } state_t;

  localparam int unsigned MAX_LOG2_N = 14;
  localparam int unsigned MAX_A_BIT  = MAX_LOG2_N - 2;

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_A_BIT-1:0] bitrev(input logic [MAX_A_BIT-1:0] v,
                                                  input int unsigned w);
    logic [MAX_A_BIT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  // A requested stage count of 0 or beyond the transform depth runs every stage.
  function automatic logic [3:0] clamp_st(input logic [3:0] n, input int unsigned log2n);
    if (n == 4'd0 || 32'(n) > log2n - 1) return 4'(log2n - 1);
    return n;
  endfunction

endpackage

// File: rtl/fht_control_param_if.sv
// Control/address bundle between the sequencer and its RAM/ROM/butterfly neighbours.
interface fht_control_param_if #(
  parameter int unsigned A_BIT = 8,
  parameter int unsigned C_BIT = 8
);
  logic             iSTART;
  logic             iABORT;
  logic             iSTALL;
  logic [3:0]       iNUM_ST;
  logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic [C_BIT-1:0] oADDR_COEF;
  logic             oWE_A, oWE_B, oSOURCE_A;
  logic             oST_ZERO, oST_LAST;
  logic [3:0]       oSTAGE;
  logic             oRDY, oDONE;

  modport slave (
    input  iSTART, iABORT, iSTALL, iNUM_ST,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oADDR_COEF, oWE_A, oWE_B, oSOURCE_A,
    output oST_ZERO, oST_LAST, oSTAGE, oRDY, oDONE
  );

  modport master (
    output iSTART, iABORT, iSTALL, iNUM_ST,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oADDR_COEF, oWE_A, oWE_B, oSOURCE_A,
    input  oST_ZERO, oST_LAST, oSTAGE, oRDY, oDONE
  );
endinterface

// File: rtl/fht_control_param_addr_delay.sv
// Read-address to write-address delay line: shifts only when enabled, flush clears every stage.
module fht_addr_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/fht_control_param.sv
// Parametrised FHT sequencer: per-stage read/coef address generation, delayed writes,
// stall/abort handling and a completion pulse.
module fht_control_param
  import fht_pkg::*;
#(
  parameter int unsigned LOG2_N   = 10,
  parameter int unsigned A_BIT    = LOG2_N - 2,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned C_BIT    = LOG2_N - 2
) (
  input logic iCLK,
  input logic iRESET,
  fht_control_param_if.slave bus
);
  localparam int unsigned      DW         = 4 * A_BIT + 2;
  localparam logic [A_BIT-1:0] T_LAST     = '1;
  localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_t           r_state;
  logic [A_BIT-1:0] r_t;
  logic [3:0]       r_drain, r_stage, r_num;
  logic             r_src, r_st_zero, r_st_last, r_rdy, r_done, r_rd_valid;
  logic [A_BIT-1:0] r_rd [4];
  logic [C_BIT-1:0] r_coef;

  logic [A_BIT-1:0] w_rd [4];
  logic [C_BIT-1:0] w_coef;
  logic [3:0]       w_num;
  logic [DW-1:0]    w_q;
  logic             w_busy_abort;

  assign w_num        = clamp_st(bus.iNUM_ST, LOG2_N);
  assign w_busy_abort = bus.iABORT && (r_state != S_IDLE);

  always_comb begin : addr_gen
    logic [A_BIT-1:0] v_rev, v_d;
    int unsigned      v_sh_d, v_sh_c;
    v_rev  = A_BIT'(bitrev(MAX_A_BIT'(r_t), A_BIT));
    v_sh_d = (r_stage == 4'd0) ? 0 : (32'(r_stage) - 1) % A_BIT;
    v_sh_c = LOG2_N - 2 - 32'(r_stage);
    v_d    = A_BIT'(1) << v_sh_d;
    w_rd   = '{default: '0};
    w_coef = '0;
    if (r_stage == 4'd0) begin
      w_rd = '{v_rev, v_rev, v_rev, v_rev};
    end else begin
      w_rd   = '{r_t, r_t, r_t ^ v_d, r_t ^ v_d};
      w_coef = C_BIT'(r_t) << v_sh_c;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      r_state    <= S_IDLE;
      r_t        <= '0;
      r_drain    <= '0;
      r_stage    <= '0;
      r_num      <= '0;
      r_src      <= 1'b1;
      r_st_zero  <= 1'b1;
      r_st_last  <= 1'b0;
      r_rdy      <= 1'b1;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd       <= '{default: '0};
      r_coef     <= '0;
    end else if (w_busy_abort) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b1;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_stage    <= '0;
      r_src      <= 1'b1;
      r_st_zero  <= 1'b1;
      r_st_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.iSTART) begin
          r_state   <= S_RUN;
          r_rdy     <= 1'b0;
          r_num     <= w_num;
          r_stage   <= '0;
          r_src     <= 1'b1;
          r_st_zero <= 1'b1;
          r_st_last <= (w_num == 4'd1);
          r_t       <= '0;
        end
      end else if (!bus.iSTALL) begin
        r_rd_valid <= 1'b0;
        case (r_state)
          S_RUN: begin
            r_rd       <= w_rd;
            r_coef     <= w_coef;
            r_rd_valid <= 1'b1;
            r_t        <= r_t + A_BIT'(1);
            if (r_t == T_LAST) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
          S_DRAIN: begin
            if (r_drain == DRAIN_LAST) begin
              r_state   <= S_NEXT;
              r_stage   <= r_stage + 4'd1;
              r_src     <= ~r_src;
              r_st_zero <= 1'b0;
              r_st_last <= (r_stage + 4'd2 == r_num);
            end else begin
              r_drain <= r_drain + 4'd1;
            end
          end
          S_NEXT: r_state <= (r_stage == r_num) ? S_FIN : S_RUN;
          S_FIN: begin
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_rdy     <= 1'b1;
            r_stage   <= '0;
            r_src     <= 1'b1;
            r_st_zero <= 1'b1;
            r_st_last <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Each entry carries its own read-set bit so the write target follows the stage it came from.
  fht_addr_delay #(
    .DEPTH(PIPE_LAT),
    .WIDTH(DW)
  ) u_delay (
    .i_clk  (iCLK),
    .i_en   (~bus.iSTALL),
    .i_flush(~iRESET | w_busy_abort),
    .i_d    ({r_rd_valid, r_src, r_rd[0], r_rd[1], r_rd[2], r_rd[3]}),
    .o_q    (w_q)
  );

  assign bus.oADDR_RD_0 = r_rd[0];
  assign bus.oADDR_RD_1 = r_rd[1];
  assign bus.oADDR_RD_2 = r_rd[2];
  assign bus.oADDR_RD_3 = r_rd[3];
  assign bus.oADDR_WR_0 = w_q[4*A_BIT-1 -: A_BIT];
  assign bus.oADDR_WR_1 = w_q[3*A_BIT-1 -: A_BIT];
  assign bus.oADDR_WR_2 = w_q[2*A_BIT-1 -: A_BIT];
  assign bus.oADDR_WR_3 = w_q[A_BIT-1:0];
  assign bus.oADDR_COEF = r_coef;
  assign bus.oWE_B      = w_q[DW-1] &  w_q[DW-2] & ~bus.iSTALL;
  assign bus.oWE_A      = w_q[DW-1] & ~w_q[DW-2] & ~bus.iSTALL;
  assign bus.oSOURCE_A  = r_src;
  assign bus.oST_ZERO   = r_st_zero;
  assign bus.oST_LAST   = r_st_last;
  assign bus.oSTAGE     = r_stage;
  assign bus.oRDY       = r_rdy;
  assign bus.oDONE      = r_done;
endmodule
